// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray/binary conversion helpers shared by the counter and its decoder.
package gray_pkg;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] max_bin(input int n);
    return MAX_W'((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// rtl/gray2bin_n.sv - Combinational N-bit Gray-to-binary decoder.
module gray2bin_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - N-bit up/down Gray counter with load, wrap or saturate.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int N        = 4,
  parameter bit SATURATE = 1'b0,
  parameter int RST_BIN  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         tc,
  output logic         wrap
);

  localparam logic [N-1:0] MAX_BIN  = N'(max_bin(N));
  localparam logic [N-1:0] RST_B    = N'(RST_BIN);
  localparam logic [N-1:0] RST_GRAY = N'(bin2gray(MAX_W'(RST_BIN)));

  logic [N-1:0] next_bin;
  logic [N-1:0] next_gray;
  logic [N-1:0] load_gray;
  logic [N-1:0] dec_bin;

  assign tc        = up_dn ? (bin_out == MAX_BIN) : (bin_out == '0);
  assign next_bin  = up_dn ? (bin_out + N'(1)) : (bin_out - N'(1));
  assign next_gray = N'(bin2gray(MAX_W'(next_bin)));
  assign load_gray = N'(bin2gray(MAX_W'(load_bin)));

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= RST_B;
      gray_out <= RST_GRAY;
      wrap     <= 1'b0;
    end else if (load) begin
      bin_out  <= load_bin;
      gray_out <= load_gray;
      wrap     <= 1'b0;
    end else if (clk_en) begin
      wrap <= tc;
      // A saturating counter blocks the end-of-range step but still flags it.
      if (!(tc && SATURATE)) begin
        bin_out  <= next_bin;
        gray_out <= next_gray;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  gray2bin_n #(.N(N)) u_dec (
    .gray (gray_out),
    .bin  (dec_bin)
  );

  a_bin_matches_gray : assert property (@(posedge clk) disable iff (rst) bin_out == dec_bin);

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - Randomized and directed bench for gray_updown_counter.
module tb_gray_updown_counter;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       up_dn;
  logic       load;
  logic [5:0] load_bin;

  logic [3:0] g4w, b4w, g4s, b4s, d4w, d4s;
  logic [5:0] g6w, b6w, g6s, b6s, d6w, d6s;
  logic       tc4w, tc4s, tc6w, tc6s;
  logic       wr4w, wr4s, wr6w, wr6s;

  int checks   = 0;
  int failures = 0;

  // Instances: 0 = N4 wrap, 1 = N4 saturate, 2 = N6 wrap, 3 = N6 saturate.
  int mv[4];
  bit mw[4];
  int mmax[4] = '{15, 15, 63, 63};
  bit msat[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [5:0] pg[4];

  logic [5:0] g[4], b[4], d[4];
  logic       t[4], w[4];

  assign g[0] = {2'b00, g4w}; assign b[0] = {2'b00, b4w}; assign d[0] = {2'b00, d4w};
  assign g[1] = {2'b00, g4s}; assign b[1] = {2'b00, b4s}; assign d[1] = {2'b00, d4s};
  assign g[2] = g6w;          assign b[2] = b6w;          assign d[2] = d6w;
  assign g[3] = g6s;          assign b[3] = b6s;          assign d[3] = d6s;
  assign t[0] = tc4w; assign t[1] = tc4s; assign t[2] = tc6w; assign t[3] = tc6s;
  assign w[0] = wr4w; assign w[1] = wr4s; assign w[2] = wr6w; assign w[3] = wr6s;

  gray_updown_counter #(.N(4), .SATURATE(1'b0), .RST_BIN(0)) u4w (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin[3:0]), .gray_out(g4w), .bin_out(b4w), .tc(tc4w), .wrap(wr4w));
  gray_updown_counter #(.N(4), .SATURATE(1'b1), .RST_BIN(0)) u4s (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin[3:0]), .gray_out(g4s), .bin_out(b4s), .tc(tc4s), .wrap(wr4s));
  gray_updown_counter #(.N(6), .SATURATE(1'b0), .RST_BIN(0)) u6w (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .gray_out(g6w), .bin_out(b6w), .tc(tc6w), .wrap(wr6w));
  gray_updown_counter #(.N(6), .SATURATE(1'b1), .RST_BIN(0)) u6s (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .gray_out(g6s), .bin_out(b6s), .tc(tc6s), .wrap(wr6s));

  gray2bin_n #(.N(4)) c4w (.gray(g4w), .bin(d4w));
  gray2bin_n #(.N(4)) c4s (.gray(g4s), .bin(d4s));
  gray2bin_n #(.N(6)) c6w (.gray(g6w), .bin(d6w));
  gray2bin_n #(.N(6)) c6s (.gray(g6s), .bin(d6s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock edge: advance every reference model, then compare all instances.
  task automatic step();
    int  old_v[4];
    bit  skip_inv;
    skip_inv = rst || load;
    for (int i = 0; i < 4; i++) begin
      old_v[i] = mv[i];
      if (rst) begin
        mv[i] = 0; mw[i] = 1'b0;
      end else if (load) begin
        mv[i] = int'(load_bin) & mmax[i]; mw[i] = 1'b0;
      end else if (clk_en) begin
        if (up_dn ? (mv[i] == mmax[i]) : (mv[i] == 0)) begin
          mw[i] = 1'b1;
          if (!msat[i]) mv[i] = up_dn ? 0 : mmax[i];
        end else begin
          mw[i] = 1'b0;
          mv[i] = up_dn ? mv[i] + 1 : mv[i] - 1;
        end
      end else begin
        mw[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bin[%0d]", i), 32'(b[i]), 32'(mv[i]));
      check($sformatf("wrap[%0d]", i), 32'(w[i]), 32'(mw[i]));
      check($sformatf("tc[%0d]", i), 32'(t[i]),
            32'(up_dn ? (mv[i] == mmax[i]) : (mv[i] == 0)));
      check($sformatf("decode[%0d]", i), 32'(d[i]), 32'(b[i]));
      if (!skip_inv)
        check($sformatf("onebit[%0d]", i), 32'($countones(g[i] ^ pg[i])),
              32'(mv[i] != old_v[i]));
      pg[i] = g[i];
    end
  endtask

  logic [3:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                              4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                              4'b1011, 4'b1001, 4'b1000, 4'b0000};
  logic [3:0] sat_bin  [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
  logic       sat_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; clk_en = 1'b0; up_dn = 1'b0; load = 1'b0; load_bin = '0;
    step();
    step();
    check("rst_gray", 32'(g4w), 32'h0);
    check("rst_bin", 32'(b4w), 32'h0);
    check("rst_wrap", 32'(wr4w), 32'h0);
    check("rst_tc_down", 32'(tc4w), 32'h1);

    rst = 1'b0; clk_en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("up_gray_%0d", k), 32'(g4w), 32'(up_seq[k]));
      check($sformatf("up_wrap_%0d", k), 32'(wr4w), 32'(k == 15));
    end

    load = 1'b1; load_bin = 6'd2;
    step();
    load = 1'b0; up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("sat_bin_%0d", k), 32'(b4s), 32'(sat_bin[k]));
      check($sformatf("sat_wrap_%0d", k), 32'(wr4s), 32'(sat_wrap[k]));
      if (k >= 1) check($sformatf("sat_gray_%0d", k), 32'(g4s), 32'h0);
    end

    load = 1'b1; load_bin = 6'd9; clk_en = 1'b1; up_dn = 1'b1;
    step();
    check("load_gray", 32'(g4w), 32'hD);
    check("load_bin", 32'(b4w), 32'h9);
    check("load_wrap", 32'(wr4w), 32'h0);
    load = 1'b0;
    step();
    check("after_load_gray", 32'(g4w), 32'hF);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("mid_bin6", 32'(b4w), 32'h6);
    rst = 1'b1; load = 1'b1; load_bin = 6'd5;
    step();
    check("mid_rst_gray", 32'(g4w), 32'h0);
    rst = 1'b0; load = 1'b0;
    step();
    check("post_rst_gray", 32'(g4w), 32'h1);

    for (int c = 0; c < 2000; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      load   = ($urandom_range(0, 15) == 0);
      clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      case ($urandom_range(0, 3))
        0:       load_bin = 6'd0;
        1:       load_bin = 6'd63;
        2:       load_bin = 6'(15 - $urandom_range(0, 2));
        default: load_bin = 6'($urandom_range(0, 63));
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
